// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 fetch stage.
//   - icode constants I_HALT..I_POPQ
//   - stat codes STAT_AOK/HLT/ADR/INS
//   - RNONE register id (no register)
//   - fetch_state_e enum for the fetch FSM
//   - ifun_legal(): function-code legality check per instruction class
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Conditional moves and jumps have 7 variants, ALU ops 4, everything else 1.
  function automatic logic ifun_legal(input logic [3:0] icode, input logic [3:0] ifun);
    logic ok;
    case (icode)
      I_RRMOVQ, I_JXX: ok = (ifun <= 4'h6);
      I_OPQ:           ok = (ifun <= 4'h3);
      default:         ok = (ifun == 4'h0);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_split.sv
// instr_split: combinational splitter of a 10-byte instruction window.
// Ports:
//   window      in  80  bytes pc..pc+9, byte 0 in [7:0]
//   pc          in  64  address of byte 0
//   icode/ifun  out 4   opcode nibbles of byte 0
//   rA/rB       out 4   register ids (RNONE when no register byte)
//   valC        out 64  little-endian constant word (0 when absent)
//   valP        out 64  pc + instruction length, wrapping
//   need_regids out 1   instruction carries a register byte
//   need_valC   out 1   instruction carries an 8-byte constant
//   instr_ok    out 1   icode/ifun combination is legal
module instr_split
  import y86_pkg::*;
(
  input  logic [79:0] window,
  input  logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        need_regids,
  output logic        need_valC,
  output logic        instr_ok
);

  logic [3:0] len_s;

  assign icode = window[7:4];
  assign ifun  = window[3:0];

  // Classify the opcode: which optional byte groups follow byte 0.
  always_comb begin
    need_regids = 1'b0;
    need_valC   = 1'b0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      I_JXX, I_CALL: need_valC = 1'b1;
      default: begin
        need_regids = 1'b0;
        need_valC   = 1'b0;
      end
    endcase
  end

  // Extract register ids and the constant; its position shifts by one byte
  // when a register byte is present.
  always_comb begin
    rA   = RNONE;
    rB   = RNONE;
    valC = 64'd0;
    if (need_regids) begin
      rA = window[15:12];
      rB = window[11:8];
    end else begin
      rA = RNONE;
      rB = RNONE;
    end
    if (need_valC && need_regids) begin
      valC = window[79:16];
    end else if (need_valC) begin
      valC = window[71:8];
    end else begin
      valC = 64'd0;
    end
  end

  assign len_s    = 4'd1 + (need_regids ? 4'd1 : 4'd0) + (need_valC ? 4'd8 : 4'd0);
  assign valP     = pc + {60'd0, len_s};
  assign instr_ok = (icode <= I_POPQ) && ifun_legal(icode, ifun);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: stateful Y86-64 SEQ fetch stage.
// Owns the PC register, requests the instruction window over a req/ack
// handshake, registers the split fields and holds them until the back end
// retires the instruction with next_pc_valid. Parks in HALT on halt,
// illegal instruction or memory error; only rst leaves HALT.
// Optional feature macro: FETCH_INSTR_CNT_EN adds the 64-bit instr_count
// output (retired instructions, a halt counts as one).
// Ports:
//   clk, rst                synchronous active-high reset
//   next_pc/next_pc_valid   retirement pulse with the following PC
//   imem_req/imem_addr      read request, address = pc
//   imem_ack/imem_data/imem_err  read completion
//   pc, icode, ifun, rA, rB, valC, valP, instr_valid, stat, halted
module fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] next_pc,
  input  logic        next_pc_valid,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [79:0] imem_data,
  input  logic        imem_err,
  output logic [63:0] pc,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic [1:0]  stat,
  output logic        halted
`ifdef FETCH_INSTR_CNT_EN
  ,
  output logic [63:0] instr_count
`endif
);

  fetch_state_e state_r, state_nxt_s;

  logic [63:0] pc_r;
  logic [3:0]  icode_r, ifun_r, ra_r, rb_r;
  logic [63:0] valc_r, valp_r;
  logic        instr_valid_r, halted_r, imem_req_r;
  logic [1:0]  stat_r, stat_nxt_s;

  logic        ack_s, load_s, retire_s, req_nxt_s;

  logic [3:0]  sp_icode_s, sp_ifun_s, sp_ra_s, sp_rb_s;
  logic [63:0] sp_valc_s, sp_valp_s;
  logic        sp_need_regids_s, sp_need_valc_s, sp_ok_s;

  instr_split u_split (
    .window      (imem_data),
    .pc          (pc_r),
    .icode       (sp_icode_s),
    .ifun        (sp_ifun_s),
    .rA          (sp_ra_s),
    .rB          (sp_rb_s),
    .valC        (sp_valc_s),
    .valP        (sp_valp_s),
    .need_regids (sp_need_regids_s),
    .need_valC   (sp_need_valc_s),
    .instr_ok    (sp_ok_s)
  );

  // An ack only counts while our own request is actually on the bus.
  assign ack_s = (state_r == ST_FETCH) && imem_req_r && imem_ack;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        if (ack_s) begin
          if (imem_err || !sp_ok_s || (sp_icode_s == I_HALT)) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (next_pc_valid) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/control decode: what the register bank captures this cycle.
  always_comb begin
    load_s     = 1'b0;
    retire_s   = 1'b0;
    req_nxt_s  = 1'b0;
    stat_nxt_s = stat_r;
    case (state_r)
      ST_FETCH: begin
        // The request rises one cycle into FETCH and drops with the ack.
        req_nxt_s = !ack_s;
        if (ack_s) begin
          if (imem_err) begin
            stat_nxt_s = STAT_ADR;
          end else if (!sp_ok_s) begin
            stat_nxt_s = STAT_INS;
          end else if (sp_icode_s == I_HALT) begin
            stat_nxt_s = STAT_HLT;
            load_s     = 1'b1;
          end else begin
            stat_nxt_s = STAT_AOK;
            load_s     = 1'b1;
          end
        end else begin
          stat_nxt_s = stat_r;
        end
      end
      ST_HOLD: retire_s = next_pc_valid;
      ST_IDLE, ST_HALT: begin
        load_s   = 1'b0;
        retire_s = 1'b0;
      end
      default: begin
        load_s   = 1'b0;
        retire_s = 1'b0;
      end
    endcase
  end

  // Architectural PC, decoded fields and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      icode_r       <= I_HALT;
      ifun_r        <= 4'h0;
      ra_r          <= RNONE;
      rb_r          <= RNONE;
      valc_r        <= 64'd0;
      valp_r        <= 64'd0;
      instr_valid_r <= 1'b0;
      stat_r        <= STAT_AOK;
      halted_r      <= 1'b0;
      imem_req_r    <= 1'b0;
    end else begin
      imem_req_r <= req_nxt_s;
      halted_r   <= (state_nxt_s == ST_HALT);
      stat_r     <= stat_nxt_s;
      if (retire_s) begin
        pc_r <= next_pc;
      end
      if (ack_s) begin
        instr_valid_r <= load_s;
      end else if (retire_s) begin
        instr_valid_r <= 1'b0;
      end
      if (load_s) begin
        icode_r <= sp_icode_s;
        ifun_r  <= sp_ifun_s;
        // Redundant gating keeps RNONE/zero even if the splitter misbehaves.
        ra_r    <= sp_need_regids_s ? sp_ra_s : RNONE;
        rb_r    <= sp_need_regids_s ? sp_rb_s : RNONE;
        valc_r  <= sp_need_valc_s ? sp_valc_s : 64'd0;
        valp_r  <= sp_valp_s;
      end
    end
  end

`ifdef FETCH_INSTR_CNT_EN
  logic [63:0] count_r;

  // Retired-instruction counter; a fetched halt is counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 64'd0;
    end else if (retire_s || (ack_s && (stat_nxt_s == STAT_HLT))) begin
      count_r <= count_r + 64'd1;
    end
  end

  assign instr_count = count_r;
`else
`endif

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign icode       = icode_r;
  assign ifun        = ifun_r;
  assign rA          = ra_r;
  assign rB          = rb_r;
  assign valC        = valc_r;
  assign valP        = valp_r;
  assign instr_valid = instr_valid_r;
  assign stat        = stat_r;
  assign halted      = halted_r;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Stateful fetch stage of the Y86-64 SEQ processor; the consumer of the next-PC value produced by the PC-update stage. Holds the architectural PC register, issues instruction-memory reads over a req/ack handshake, splits the returned 10-byte window into icode/ifun/rA/rB/valC/valP, and holds those fields until the back end signals the next PC. Detects halt, invalid-instruction and memory-address errors and parks in a halted state.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- next_pc  in  64  next PC from the PC-update stage
- next_pc_valid  in  1  single-cycle pulse: current instruction retired, next_pc valid
- imem_req  out  1  instruction-memory read request
- imem_addr  out  64  read address (= pc)
- imem_ack  in  1  read complete; imem_data/imem_err valid this cycle
- imem_data  in  80  bytes addr..addr+9, byte 0 in [7:0]
- imem_err  in  1  address invalid (qualified by imem_ack)
- pc  out  64  current PC register
- icode, ifun, rA, rB  out  4 each  decoded fields
- valC  out  64  constant word, little-endian
- valP  out  64  pc + instruction length
- instr_valid  out  1  fields valid; held until retirement
- stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS
- halted  out  1  fetch stopped; only rst exits

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- Reset: pc=RESET_PC, state IDLE, imem_req=0, instr_valid=0, stat=AOK, halted=0, icode=ifun=0, rA=rB=4'hF, valC=valP=0.
- IDLE: unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. On ack:
  - imem_err=1: stat=ADR, instr_valid=0, -> HALT.
  - icode>0xB or illegal ifun (icode 2 or 7: ifun>6; icode 6: ifun>3; all others: ifun!=0): stat=INS, instr_valid=0, -> HALT.
  - icode 0 (halt): register fields, instr_valid=1, stat=HLT, -> HALT.
  - otherwise: register fields, instr_valid=1, stat=AOK, -> HOLD.
- Length: icodes 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10.
- Register byte (icodes 2-6,A,B): byte 1, rA=[7:4], rB=[3:0]; otherwise rA=rB=4'hF.
- valC: bytes 2..9 if register byte present, else bytes 1..8 (icodes 3,4,5,7,8); otherwise 0.
- valP = pc + length, 64-bit wrap (pc=64'hFFFF_FFFF_FFFF_FFFF, nop -> valP=0).
- HOLD: outputs stable. On next_pc_valid: pc<=next_pc, instr_valid<=0, -> FETCH.
- HALT: imem_req=0, halted=1, fields and stat frozen; next_pc_valid ignored.
- next_pc_valid outside HOLD is ignored. imem_ack outside FETCH is ignored.
- rst in any state, including mid-request, returns to reset values next edge; an outstanding request is abandoned.

## Timing
- Request asserted the cycle after entering FETCH; from IDLE, first imem_req one cycle after rst deasserts.
- Fields/instr_valid/stat registered: valid the cycle after imem_ack.
- Zero-wait memory (ack in first request cycle): one instruction per 3 cycles with next_pc_valid asserted in the first HOLD cycle.
- halted asserts the cycle after the terminating ack.

## Configuration
- FETCH_INSTR_CNT_EN defined: extra output instr_count (64 bits), reset to 0, incremented on each next_pc_valid accepted in HOLD, plus 1 when entering HALT with stat=HLT; wraps modulo 2^64.
- Undefined: no counter, port absent.

## Structure
- Shared package y86_pkg: icode constants (I_HALT..I_POPQ), stat codes, RNONE=4'hF, fetch state enum.
- Sub-module instr_split: combinational; 80-bit window + pc -> icode, ifun, rA, rB, valC, valP, need_regids, need_valC, instr_ok. fetch_unit owns FSM and registers.

## Test plan
- Reset, zero-wait memory, nop at 0 -> imem_addr=0, icode=1, valP=1, rA=rB=F, stat=AOK; next_pc_valid with next_pc=1 -> next imem_addr=1.
- irmovq 30 F2 0807060504030201 at 0x100 -> icode=3, rA=F, rB=2, valC=64'h0102030405060708, valP=0x10A.
- jXX 73 + 8-byte 0x40, 4-cycle ack delay -> imem_req/addr stable 4 cycles, ifun=3, valC=0x40, valP=pc+9.
- Byte 0xC0 -> stat=INS, instr_valid=0, halted=1; later next_pc_valid ignored. Byte 0x00 -> stat=HLT, instr_valid=1.
- imem_err with ack -> stat=ADR, halted=1, imem_req=0; rst -> pc=RESET_PC, stat=AOK, fetch resumes.
- rst asserted mid-FETCH before ack; ack arriving in the rst cycle ignored -> instr_valid=0, state IDLE, then new request at RESET_PC.
